// File: rtl/e203_exu_flush_arb_pkg.sv
// ============================================================================
// Module  : e203_exu_flush_arb_pkg
// Brief   : Shared encodings for the EXU flush arbiter slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

package e203_exu_flush_arb_pkg;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_busy = 1'b1;

  localparam logic c_src_excp = 1'b1;
  localparam logic c_src_brch = 1'b0;

  localparam int c_pc_size_def = `E203_PC_SIZE;

endpackage

`default_nettype wire

// File: rtl/e203_flush_evt_cnt.sv
// ============================================================================
// Module  : e203_flush_evt_cnt
// Brief   : Enable-gated wrapping event counter, async active-low reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module e203_flush_evt_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/e203_exu_flush_arb.sv
// ============================================================================
// Module  : e203_exu_flush_arb
// Brief   : Registered one-at-a-time flush scheduler, exception over branch.
//           Optional E203_FLUSH_ARB_PC_ADD_EN registers op1+op2 as pipe_flush_pc.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module e203_exu_flush_arb
  import e203_exu_flush_arb_pkg::*;
#(
  parameter int PC_SIZE = c_pc_size_def,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               excp_flush_req,
  output logic               excp_flush_ack,
  input  logic [PC_SIZE-1:0] excp_flush_add_op1,
  input  logic [PC_SIZE-1:0] excp_flush_add_op2,

  input  logic               brch_flush_req,
  output logic               brch_flush_ack,
  input  logic [PC_SIZE-1:0] brch_flush_add_op1,
  input  logic [PC_SIZE-1:0] brch_flush_add_op2,

  output logic               pipe_flush_req,
  input  logic               pipe_flush_ack,
  output logic [PC_SIZE-1:0] pipe_flush_add_op1,
  output logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_src,
`ifdef E203_FLUSH_ARB_PC_ADD_EN
  output logic [PC_SIZE-1:0] pipe_flush_pc,
`endif
  output logic [CNT_W-1:0]   excp_flush_cnt,
  output logic [CNT_W-1:0]   brch_flush_cnt
);

  logic [0:0]         r_state;
  logic [PC_SIZE-1:0] r_op1;
  logic [PC_SIZE-1:0] r_op2;
  logic               r_src;

  logic               w_busy;
  logic               w_retire;
  logic               w_accept_ok;
  logic               w_accept;
  logic [PC_SIZE-1:0] w_win_op1;
  logic [PC_SIZE-1:0] w_win_op2;

  assign w_busy      = (r_state == c_st_busy);
  assign w_retire    = w_busy & pipe_flush_ack;
  // A retiring flush frees the slot in the same cycle, so a waiting request
  // can be taken without an idle bubble.
  assign w_accept_ok = ~w_busy | pipe_flush_ack;

  assign excp_flush_ack = w_accept_ok & excp_flush_req;
  assign brch_flush_ack = w_accept_ok & brch_flush_req & ~excp_flush_req;
  assign w_accept       = excp_flush_ack | brch_flush_ack;

  assign w_win_op1 = excp_flush_req ? excp_flush_add_op1 : brch_flush_add_op1;
  assign w_win_op2 = excp_flush_req ? excp_flush_add_op2 : brch_flush_add_op2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else if (w_accept) begin
      r_state <= c_st_busy;
    end else if (w_retire) begin
      r_state <= c_st_idle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1 <= '0;
      r_op2 <= '0;
      r_src <= c_src_brch;
    end else if (w_accept) begin
      r_op1 <= w_win_op1;
      r_op2 <= w_win_op2;
      r_src <= excp_flush_req ? c_src_excp : c_src_brch;
    end
  end

`ifdef E203_FLUSH_ARB_PC_ADD_EN
  logic [PC_SIZE-1:0] r_pc;

  // Carry out of the target sum is dropped; PC space wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (w_accept) begin
      r_pc <= w_win_op1 + w_win_op2;
    end
  end

  assign pipe_flush_pc = r_pc;
`endif

  assign pipe_flush_req     = w_busy;
  assign pipe_flush_add_op1 = r_op1;
  assign pipe_flush_add_op2 = r_op2;
  assign pipe_flush_src     = r_src;

  e203_flush_evt_cnt #(
    .CNT_W (CNT_W)
  ) u_excp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_retire & (r_src == c_src_excp)),
    .cnt   (excp_flush_cnt)
  );

  e203_flush_evt_cnt #(
    .CNT_W (CNT_W)
  ) u_brch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_retire & (r_src == c_src_brch)),
    .cnt   (brch_flush_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_e203_exu_flush_arb.sv
// ============================================================================
// Module  : tb_e203_exu_flush_arb
// Brief   : Self-checking bench: vector table, corner sequences, random run.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_e203_exu_flush_arb;

  localparam int PCW      = 32;
  localparam int TB_CNT_W = 8;   // narrow counters so the wrap is reached quickly
  localparam int CNT_MOD  = 1 << TB_CNT_W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           excp_flush_req = 1'b0, brch_flush_req = 1'b0, pipe_flush_ack = 1'b0;
  logic [PCW-1:0] excp_flush_add_op1 = '0, excp_flush_add_op2 = '0;
  logic [PCW-1:0] brch_flush_add_op1 = '0, brch_flush_add_op2 = '0;
  logic           excp_flush_ack, brch_flush_ack, pipe_flush_req, pipe_flush_src;
  logic [PCW-1:0] pipe_flush_add_op1, pipe_flush_add_op2;
  logic [TB_CNT_W-1:0] excp_flush_cnt, brch_flush_cnt;
`ifdef E203_FLUSH_ARB_PC_ADD_EN
  logic [PCW-1:0] pipe_flush_pc;
`endif

  e203_exu_flush_arb #(.PC_SIZE(PCW), .CNT_W(TB_CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .excp_flush_req     (excp_flush_req),
    .excp_flush_ack     (excp_flush_ack),
    .excp_flush_add_op1 (excp_flush_add_op1),
    .excp_flush_add_op2 (excp_flush_add_op2),
    .brch_flush_req     (brch_flush_req),
    .brch_flush_ack     (brch_flush_ack),
    .brch_flush_add_op1 (brch_flush_add_op1),
    .brch_flush_add_op2 (brch_flush_add_op2),
    .pipe_flush_req     (pipe_flush_req),
    .pipe_flush_ack     (pipe_flush_ack),
    .pipe_flush_add_op1 (pipe_flush_add_op1),
    .pipe_flush_add_op2 (pipe_flush_add_op2),
    .pipe_flush_src     (pipe_flush_src),
`ifdef E203_FLUSH_ARB_PC_ADD_EN
    .pipe_flush_pc      (pipe_flush_pc),
`endif
    .excp_flush_cnt     (excp_flush_cnt),
    .brch_flush_cnt     (brch_flush_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: a pending-flush slot holding at most one target, plus tallies.
  typedef struct {
    logic [PCW-1:0] op1;
    logic [PCW-1:0] op2;
    bit             src;
  } tgt_t;
  tgt_t held[$];
  int   cnt_e = 0;
  int   cnt_b = 0;
  bit   m_eack, m_back;

  typedef struct {
    bit             ereq, breq, pack;
    logic [PCW-1:0] e1, e2, b1, b2;
    bit             x_eack, x_back, x_preq, chk_op;
    logic [PCW-1:0] x_op1, x_op2;
    bit             x_src;
    int             x_ecnt, x_bcnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit er, input bit br, input bit pa,
                       input logic [PCW-1:0] e1, input logic [PCW-1:0] e2,
                       input logic [PCW-1:0] b1, input logic [PCW-1:0] b2);
    excp_flush_req     = er;
    brch_flush_req     = br;
    pipe_flush_ack     = pa;
    excp_flush_add_op1 = e1;
    excp_flush_add_op2 = e2;
    brch_flush_add_op1 = b1;
    brch_flush_add_op2 = b2;
  endtask

  task automatic check_model();
    bit free;
    free   = (held.size() == 0) || pipe_flush_ack;
    m_eack = free && excp_flush_req;
    m_back = free && brch_flush_req && !excp_flush_req;
    chk("m_excp_ack", 32'(excp_flush_ack), 32'(m_eack));
    chk("m_brch_ack", 32'(brch_flush_ack), 32'(m_back));
    chk("m_pipe_req", 32'(pipe_flush_req), 32'(held.size() != 0));
    chk("m_excp_cnt", 32'(excp_flush_cnt), cnt_e);
    chk("m_brch_cnt", 32'(brch_flush_cnt), cnt_b);
    if (held.size() != 0) begin
      chk("m_op1", pipe_flush_add_op1, held[0].op1);
      chk("m_op2", pipe_flush_add_op2, held[0].op2);
      chk("m_src", 32'(pipe_flush_src), 32'(held[0].src));
`ifdef E203_FLUSH_ARB_PC_ADD_EN
      chk("m_pc", pipe_flush_pc, held[0].op1 + held[0].op2);
`endif
    end
  endtask

  task automatic advance();
    tgt_t t;
    @(posedge clk);
    if (held.size() != 0 && pipe_flush_ack) begin
      if (held[0].src) cnt_e = (cnt_e + 1) % CNT_MOD;
      else             cnt_b = (cnt_b + 1) % CNT_MOD;
      void'(held.pop_front());
    end
    if (m_eack) begin
      t.op1 = excp_flush_add_op1; t.op2 = excp_flush_add_op2; t.src = 1'b1;
      held.push_back(t);
    end else if (m_back) begin
      t.op1 = brch_flush_add_op1; t.op2 = brch_flush_add_op2; t.src = 1'b0;
      held.push_back(t);
    end
    #1;
  endtask

  task automatic step(input bit er, input bit br, input bit pa,
                      input logic [PCW-1:0] e1, input logic [PCW-1:0] e2,
                      input logic [PCW-1:0] b1, input logic [PCW-1:0] b2);
    drive(er, br, pa, e1, e2, b1, b2);
    #1;
    check_model();
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[12];

  initial begin
    //                ereq breq pack  e1            e2     b1            b2   eack back preq chk  op1           op2   src ecnt bcnt
    tbl[0]  = '{0,1,0, 32'h0,         32'h0, 32'h8000_0100, 32'h4, 0,1,0,0, 32'h0,         32'h0, 0, 0,0};
    tbl[1]  = '{0,0,0, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,1,1, 32'h8000_0100, 32'h4, 0, 0,0};
    tbl[2]  = '{0,0,0, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,1,1, 32'h8000_0100, 32'h4, 0, 0,0};
    tbl[3]  = '{0,0,0, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,1,1, 32'h8000_0100, 32'h4, 0, 0,0};
    tbl[4]  = '{0,0,1, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,1,1, 32'h8000_0100, 32'h4, 0, 0,0};
    tbl[5]  = '{0,0,0, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,0,0, 32'h0,         32'h0, 0, 0,1};
    tbl[6]  = '{1,1,0, 32'h8000_0000, 32'h0, 32'h100,       32'h8, 1,0,0,0, 32'h0,         32'h0, 0, 0,1};
    tbl[7]  = '{0,1,0, 32'h0,         32'h0, 32'h100,       32'h8, 0,0,1,1, 32'h8000_0000, 32'h0, 1, 0,1};
    tbl[8]  = '{0,1,1, 32'h0,         32'h0, 32'h100,       32'h8, 0,1,1,1, 32'h8000_0000, 32'h0, 1, 0,1};
    tbl[9]  = '{0,0,0, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,1,1, 32'h100,       32'h8, 0, 1,1};
    tbl[10] = '{0,0,1, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,1,1, 32'h100,       32'h8, 0, 1,1};
    tbl[11] = '{0,0,0, 32'h0,         32'h0, 32'h0,         32'h0, 0,0,0,0, 32'h0,         32'h0, 0, 1,2};

    // Reset state
    #3;
    chk("rst_pipe_req", 32'(pipe_flush_req), 32'h0);
    chk("rst_op1", pipe_flush_add_op1, 32'h0);
    chk("rst_op2", pipe_flush_add_op2, 32'h0);
    chk("rst_src", 32'(pipe_flush_src), 32'h0);
    chk("rst_ecnt", 32'(excp_flush_cnt), 32'h0);
    chk("rst_bcnt", 32'(brch_flush_cnt), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lone branch followed by simultaneous exception/branch
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ereq, tbl[i].breq, tbl[i].pack, tbl[i].e1, tbl[i].e2, tbl[i].b1, tbl[i].b2);
      #1;
      chk($sformatf("v%0d_excp_ack", i), 32'(excp_flush_ack), 32'(tbl[i].x_eack));
      chk($sformatf("v%0d_brch_ack", i), 32'(brch_flush_ack), 32'(tbl[i].x_back));
      chk($sformatf("v%0d_pipe_req", i), 32'(pipe_flush_req), 32'(tbl[i].x_preq));
      chk($sformatf("v%0d_excp_cnt", i), 32'(excp_flush_cnt), tbl[i].x_ecnt);
      chk($sformatf("v%0d_brch_cnt", i), 32'(brch_flush_cnt), tbl[i].x_bcnt);
      if (tbl[i].chk_op) begin
        chk($sformatf("v%0d_op1", i), pipe_flush_add_op1, tbl[i].x_op1);
        chk($sformatf("v%0d_op2", i), pipe_flush_add_op2, tbl[i].x_op2);
        chk($sformatf("v%0d_src", i), 32'(pipe_flush_src), 32'(tbl[i].x_src));
      end
      check_model();
      advance();
    end

    // No preemption: exception waits behind a held branch
    step(0, 1, 0, 32'h0, 32'h0, 32'h2000, 32'h10);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h3000, 32'h4, 32'h0, 32'h0);
      #1;
      chk("nopre_excp_ack", 32'(excp_flush_ack), 32'h0);
      chk("nopre_op1", pipe_flush_add_op1, 32'h2000);
      check_model();
      advance();
    end
    drive(1, 0, 1, 32'h3000, 32'h4, 32'h0, 32'h0);
    #1;
    chk("nopre_excp_ack_on_retire", 32'(excp_flush_ack), 32'h1);
    check_model();
    advance();
    step(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Back-to-back exceptions through the counter wrap
    for (int i = 0; i < CNT_MOD + 4; i++) begin
      drive(1, 0, 1, 32'h4000 + 32'(i), 32'h0, 32'h0, 32'h0);
      #1;
      if (i > 0) chk("b2b_pipe_req", 32'(pipe_flush_req), 32'h1);
      check_model();
      advance();
    end
    step(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset while busy
    step(0, 1, 0, 32'h0, 32'h0, 32'h5000, 32'h8);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pipe_req", 32'(pipe_flush_req), 32'h0);
    chk("arst_op1", pipe_flush_add_op1, 32'h0);
    chk("arst_op2", pipe_flush_add_op2, 32'h0);
    chk("arst_ecnt", 32'(excp_flush_cnt), 32'h0);
    chk("arst_bcnt", 32'(brch_flush_cnt), 32'h0);
    held.delete();
    cnt_e = 0;
    cnt_b = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

`ifdef E203_FLUSH_ARB_PC_ADD_EN
    step(1, 0, 0, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0);
    drive(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("feat_pc", pipe_flush_pc, 32'h0000_0004);
    check_model();
    advance();
`endif

    // Randomized traffic against the reference slot
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           $urandom, $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e203_exu_flush_arb.md
Name: e203_exu_flush_arb

Overview:
- Arbitrates between the two pipeline-flush sources in the EXU: the non-ALU exception/IRQ commit flush and the branch-resolve flush (mispredict, fence.i, mret, dret).
- Registers the winning flush target and presents one stable flush request to the IFU until the IFU acknowledges it.
- Sits between the commit stage and the IFU flush interface.
- Replaces ad-hoc combinational priority masking with a registered, one-at-a-time flush scheduler.

Parameters:
- PC_SIZE, 32, width of PC and adder operands (matches E203_PC_SIZE).
- CNT_W, 16, width of each flush-event counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- excp_flush_req  in  1  exception/IRQ flush request; held until excp_flush_ack
- excp_flush_ack  out  1  exception flush accepted (latched) this cycle
- excp_flush_add_op1  in  PC_SIZE  exception target operand 1
- excp_flush_add_op2  in  PC_SIZE  exception target operand 2
- brch_flush_req  in  1  branch-resolve flush request; held until brch_flush_ack
- brch_flush_ack  out  1  branch flush accepted this cycle
- brch_flush_add_op1  in  PC_SIZE  branch target operand 1
- brch_flush_add_op2  in  PC_SIZE  branch target operand 2
- pipe_flush_req  out  1  flush request to IFU
- pipe_flush_ack  in  1  IFU accepts flush
- pipe_flush_add_op1  out  PC_SIZE  registered target operand 1
- pipe_flush_add_op2  out  PC_SIZE  registered target operand 2
- pipe_flush_src  out  1  source of the held flush: 1 = exception, 0 = branch
- excp_flush_cnt  out  CNT_W  count of completed exception flushes
- brch_flush_cnt  out  CNT_W  count of completed branch flushes

Behaviour:
- FSM states: IDLE, BUSY. Reset state is IDLE.
- Reset values: all outputs 0, hold registers 0, counters 0. Asserting rst_n mid-operation aborts any held flush; nothing is replayed.
- Acceptance: allowed when state is IDLE, or when state is BUSY and pipe_flush_ack=1 in that cycle (back-to-back).
  - Priority is fixed: exception over branch.
  - excp_flush_ack = accept_ok & excp_flush_req.
  - brch_flush_ack = accept_ok & brch_flush_req & ~excp_flush_req.
  - Both acks are combinational from the current req and state; they are never asserted together.
- On an accept:
  - Latch the winner's op1/op2 into pipe_flush_add_op1/op2.
  - Set pipe_flush_src to the winner.
  - Next state is BUSY.
- Latency: pipe_flush_req asserts the cycle after the accept (1 cycle).
- BUSY:
  - pipe_flush_req=1; op1, op2 and src are held stable until pipe_flush_ack.
  - On pipe_flush_ack with no new request: go to IDLE; pipe_flush_req deasserts next cycle.
  - On pipe_flush_ack with a new request: accept it in the same cycle and stay BUSY; the new target appears next cycle.
- No preemption: an exception request arriving while a branch flush is held waits until the held flush is acked.
- A losing branch request stays pending (unacked); the requester must keep it held.
- Counters:
  - On pipe_flush_ack & BUSY, increment the counter selected by pipe_flush_src.
  - Counters wrap modulo 2^CNT_W.
  - Counter value is visible the cycle after the ack.
- pipe_flush_ack while IDLE is ignored.
- Requests dropped before ack are legal; no state is changed.
- Target arithmetic is not performed unless the optional feature is enabled; the IFU adds op1+op2.

Optional Feature:
- Macro: E203_FLUSH_ARB_PC_ADD_EN.
- When defined:
  - Adds output pipe_flush_pc [PC_SIZE].
  - At accept time, the block registers the winner's op1+op2 (truncated to PC_SIZE, carry discarded) together with op1/op2, taking the adder off the IFU timing path.
  - pipe_flush_pc has the same timing and hold rules as op1/op2 and resets to 0.
- When undefined: the port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines: FSM state encodings (IDLE=1'b0, BUSY=1'b1), source encodings (SRC_EXCP=1, SRC_BRCH=0), PC_SIZE default from E203_PC_SIZE.
- One natural sub-module, e203_flush_evt_cnt: an enable-gated wrapping CNT_W counter with async active-low reset, instantiated twice.

Test Plan:
- Lone branch: brch_flush_req=1, op1=0x8000_0100, op2=0x4, pipe_flush_ack held low 3 cycles then high.
  - brch_flush_ack pulses in cycle 0.
  - pipe_flush_req=1 in cycles 1-4 with op1/op2 stable; it drops in cycle 5.
  - brch_flush_cnt=1.
- Simultaneous: excp op1=0x8000_0000/op2=0 and brch op1=0x100/op2=0x8 in the same cycle.
  - Exception is acked first, src=1.
  - After pipe_flush_ack, the branch is acked in the same cycle; the branch target appears the next cycle with src=0.
- No preemption: branch held in BUSY, excp_flush_req rises.
  - excp_flush_ack stays 0 until pipe_flush_ack; op1/op2 stay unchanged.
- Back-to-back: continuous excp_flush_req with pipe_flush_ack=1 every cycle.
  - pipe_flush_req stays 1 with no IDLE gap.
  - excp_flush_cnt increments each cycle.
  - Preload the counter to 0xFFFF and verify it wraps to 0x0000.
- Reset mid-flush: rst_n low while BUSY.
  - pipe_flush_req, counters and op registers read 0 immediately (asynchronous).
  - After release, state is IDLE.
- Feature on (E203_FLUSH_ARB_PC_ADD_EN): op1=0xFFFF_FFFC, op2=0x8.
  - pipe_flush_pc=0x0000_0004, valid from the cycle after accept.
